// File: rtl/cluster_pkg.sv
// Shared types and constants for the clustering assignment write-back path.
package cluster_pkg;

    localparam int ENTRY_W   = 16;
    localparam int N_DEFAULT = 4096;

    localparam logic [2:0] STAGE_ASSIGN = 3'd6;
    localparam logic [2:0] STAGE_DONE   = 3'd7;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} collect_state_e;

    typedef struct packed {
        logic [ENTRY_W-1:0] center_id;
        logic [ENTRY_W-1:0] pos;
        logic [ENTRY_W-1:0] dnorm;
    } assign_entry_t;

endpackage

// File: rtl/center_assign_collector_lane_compactor.sv
// Squeezes kept lanes down to the lowest slots in ascending lane order and counts them.
module lane_compactor
    import cluster_pkg::*;
#(
    parameter int PARALLEL = 2,
    parameter int K_W      = $clog2(PARALLEL + 1)
) (
    input  logic          [PARALLEL-1:0] keep,
    input  assign_entry_t [PARALLEL-1:0] lane,
    output assign_entry_t [PARALLEL-1:0] slot,
    output logic          [K_W-1:0]      k
);

    // Slot index of a kept lane is the number of kept lanes below it.
    always_comb begin
        int cnt;
        cnt  = 0;
        slot = '0;
        for (int i = 0; i < PARALLEL; i++) begin
            if (keep[i]) begin
                for (int j = 0; j < PARALLEL; j++) begin
                    if (j == cnt) slot[j] = lane[i];
                end
                cnt++;
            end
        end
        k = K_W'(cnt);
    end

endmodule

// File: rtl/center_assign_collector.sv
// Collects assigned lanes from the stage-6 beat into a FIFO and streams them out one per cycle.
module center_assign_collector
    import cluster_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int WIDTH    = ENTRY_W,
    parameter int PARALLEL = 2,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 13
) (
    input  logic                      CLK_i,
    input  logic                      RST_i,
    input  logic [2:0]                stage_i,
    input  logic                      finished_i,
    input  logic [PARALLEL*WIDTH-1:0] center_id_i,
    input  logic [PARALLEL*WIDTH-1:0] dnorm_i,
    input  logic [PARALLEL*WIDTH-1:0] pos_i,
    output logic                      stall_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [WIDTH-1:0]          out_center_id_o,
    output logic [WIDTH-1:0]          out_pos_o,
    output logic [WIDTH-1:0]          out_dnorm_o,
    output logic [CNT_W-1:0]          assigned_cnt_o,
    output logic                      done_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FCW   = $clog2(DEPTH + 1);
    localparam int K_W   = $clog2(PARALLEL + 1);
    localparam int SUM_W = CNT_W + 1;

    collect_state_e                state;
    assign_entry_t                 mem [DEPTH];
    logic          [PTR_W-1:0]     wptr, rptr;
    logic          [FCW-1:0]       count;
    logic          [PARALLEL-1:0]  keep;
    assign_entry_t [PARALLEL-1:0]  lane, slot;
    logic          [K_W-1:0]       k_raw, k;
    logic                          accept, pop;
    logic          [SUM_W-1:0]     cnt_sum;

    for (genvar g = 0; g < PARALLEL; g++) begin : g_lane
        assign keep[g] = center_id_i[g*WIDTH +: WIDTH] != WIDTH'(N);
        assign lane[g] = '{center_id: center_id_i[g*WIDTH +: WIDTH],
                           pos:       pos_i[g*WIDTH +: WIDTH],
                           dnorm:     dnorm_i[g*WIDTH +: WIDTH]};
    end

    lane_compactor #(.PARALLEL(PARALLEL), .K_W(K_W)) u_compact (
        .keep (keep),
        .lane (lane),
        .slot (slot),
        .k    (k_raw)
    );

    // Room for a worst-case beat is reserved, so an accepted beat never overflows.
    assign stall_o     = (FCW'(DEPTH) - count) < FCW'(PARALLEL);
    assign accept      = (state == COLLECT) && (stage_i == STAGE_ASSIGN) && !stall_o;
    assign k           = accept ? k_raw : '0;
    assign out_valid_o = count != '0;
    assign pop         = out_valid_o && out_ready_i;
    assign cnt_sum     = {1'b0, assigned_cnt_o} + SUM_W'(k);

    assign out_center_id_o = mem[rptr].center_id;
    assign out_pos_o       = mem[rptr].pos;
    assign out_dnorm_o     = mem[rptr].dnorm;

    always_ff @(posedge CLK_i) begin
        for (int j = 0; j < PARALLEL; j++) begin
            if (j < int'(k)) mem[wptr + PTR_W'(j)] <= slot[j];
        end
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state          <= IDLE;
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            assigned_cnt_o <= '0;
            done_o         <= 1'b0;
        end else begin
            count          <= count + FCW'(k) - FCW'(pop);
            wptr           <= wptr + PTR_W'(k);
            rptr           <= rptr + PTR_W'(pop);
            assigned_cnt_o <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            case (state)
                IDLE:    if (stage_i == STAGE_ASSIGN) state <= COLLECT;
                COLLECT: if (finished_i) state <= DRAIN;
                DRAIN: begin
                    if (count == '0 && k == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
